// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, constants and width helper for the LED scheduler
package led_pkg;

  localparam int LED_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Counter width for a count range of n, never narrower than one bit
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_sched_if.sv
// rtl/led_sched_if.sv - requester handshake and LED status bundle
interface led_sched_if import led_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = LED_W
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_pattern;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [WIDTH-1:0]         led;

  modport master (
    output req_valid, req_pattern,
    input  req_ready, grant, busy, led
  );

  modport slave (
    input  req_valid, req_pattern,
    output req_ready, grant, busy, led
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter import led_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_idx
);

  // Walk ptr+1, ptr+2, ... modulo NUM_REQ; the first valid requester wins
  always_comb begin
    int               w_cand;
    logic [PTR_W-1:0] w_pos;
    logic             w_found;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    w_pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      w_pos = PTR_W'(w_cand);
      if (!w_found && i_en && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/led_sched.sv
// rtl/led_sched.sv - round-robin time-multiplexer of requester patterns onto the LED bank
module led_sched import led_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = LED_W,
  parameter int HOLD    = 12000000,
  parameter int HB_HALF = 6000000
) (
  input logic         clk,
  input logic         rst_n,
  led_sched_if.slave  bus
);

  localparam int PTR_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = clog2_min1(HOLD);
  localparam int HB_W  = clog2_min1(HB_HALF);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);
  localparam logic [HB_W-1:0]  HB_LOAD  = HB_W'(HB_HALF - 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

  state_t             r_state;
  logic               r_run;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_led;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_busy;
  logic               r_hb;
  logic [HB_W-1:0]    r_hb_cnt;

  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_idx;
  logic               w_accept;
  logic               w_hb_nxt;
  logic [WIDTH-1:0]   w_idle_led;
  logic [WIDTH-1:0]   w_sel_pattern;

  // r_run keeps req_ready low until the first clock edge after reset release
  assign w_arb_en = (r_state == IDLE) && r_run;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_accept   = |w_gnt;
  assign w_hb_nxt   = (r_hb_cnt == '0) ? ~r_hb : r_hb;
  assign w_idle_led = WIDTH'(w_hb_nxt);

  // One-hot mux of the granted requester's pattern slice
  always_comb begin
    w_sel_pattern = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_pattern = w_sel_pattern | bus.req_pattern[i*WIDTH +: WIDTH];
      end
    end
  end

  // Free-running heartbeat divider, independent of the scheduler state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hb     <= 1'b0;
      r_hb_cnt <= HB_LOAD;
    end else if (r_hb_cnt == '0) begin
      r_hb     <= ~r_hb;
      r_hb_cnt <= HB_LOAD;
    end else begin
      r_hb_cnt <= r_hb_cnt - HB_W'(1);
    end
  end

  // IDLE/SHOW scheduler; led/grant/busy are loaded with their next-cycle values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
      r_ptr   <= PTR_RST;
      r_cnt   <= '0;
      r_led   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= SHOW;
            r_ptr   <= w_idx;
            r_cnt   <= CNT_LOAD;
            r_led   <= w_sel_pattern;
            r_grant <= w_gnt;
            r_busy  <= 1'b1;
          end else begin
            r_led <= w_idle_led;
          end
        end
        SHOW: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_led   <= w_idle_led;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.led       = r_led;

endmodule
